systolic_mac_pe: RTL and testbench
==================================

SYSTOLIC_MAC_PE -- requirements
Module: systolic_mac_pe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed width of the activation and weight operands.
REQ-002 SHALL have parameter ACC_W, default 24: signed partial-sum width; ACC_W >= 2*DATA_W is required.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port x_in, input, DATA_W: signed activation from the west neighbour.
REQ-006 SHALL have port x_valid_in, input, 1: x_in qualifier.
REQ-007 SHALL have port psum_in, input, ACC_W: signed partial sum from the north neighbour.
REQ-008 SHALL have port w_in, input, DATA_W: weight shift-chain input.
REQ-009 SHALL have port w_shift, input, 1: shift w_in into the shadow weight and pass the old shadow value on.
REQ-010 SHALL have port w_swap, input, 1: copy the shadow weight into the active weight.
REQ-011 SHALL have port x_out, output, DATA_W: registered x_in to the east neighbour.
REQ-012 SHALL have port x_valid_out, output, 1: registered x_valid_in.
REQ-013 SHALL have port psum_out, output, ACC_W: registered partial sum to the south neighbour.
REQ-014 SHALL have port w_out, output, DATA_W: shadow weight, forming the weight chain.
REQ-015 SHALL have port w_ready, output, 1: an active weight is loaded (state READY).
REQ-016 SHALL have port ovf, output, 1: sticky overflow flag; cleared only by reset.

Function
REQ-017 SHALL implement a two-state FSM: EMPTY (reset) -> READY on w_swap; READY stays READY (further w_swap reloads the active weight); only reset returns to EMPTY.
REQ-018 SHALL have 1-cycle latency on every datapath: x_out, x_valid_out and psum_out update on the edge after their inputs are sampled.
REQ-019 When x_valid_in=1 in READY, SHALL set psum_out <= psum_in + w_act*x_in, with a full-precision 2*DATA_W signed product sign-extended to ACC_W.
REQ-020 When x_valid_in=0, or in EMPTY, SHALL set psum_out <= psum_in (pass-through); x_out/x_valid_out forward unconditionally.
REQ-021 On w_shift=1, SHALL set w_shadow <= w_in; w_out always equals w_shadow.
REQ-022 On w_swap=1, SHALL set w_act <= w_shadow, effective the next cycle; an x_valid_in in the same cycle uses the old w_act (pass-through if EMPTY).
REQ-023 On simultaneous w_shift and w_swap, SHALL swap the pre-shift shadow value and shift the new value in.
REQ-024 SHALL wrap the ACC_W sum on overflow when saturation is compiled out; ovf is set on any signed overflow in either mode.

Reset
REQ-025 SHALL, on reset low, asynchronously clear x_out, x_valid_out, psum_out, w_out, w_shadow, w_act, ovf and w_ready to 0 and set the FSM to EMPTY, including mid-stream.
REQ-026 SHALL treat the first edge after reset deassertion as a normal cycle.

Configuration
REQ-027 SHALL support macro PE_SATURATE_EN: when defined, an overflowing sum clamps to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)) and ovf is set; when undefined, the sum wraps modulo 2^ACC_W and ovf is still set.

Structure
REQ-028 SHALL take the FSM state enum (PE_EMPTY, PE_READY) and the saturation-limit constant functions from shared package pe_pkg.
REQ-029 SHALL place the multiply-add-saturate logic in sub-module pe_mac_unit (combinational, parameters DATA_W/ACC_W); registers and FSM stay in systolic_mac_pe.

Verification
REQ-030 Load test: w_in=3 with w_shift, then w_swap; x_in=-4 valid, psum_in=10 -> psum_out=-2 one cycle later; w_ready=1.
REQ-031 EMPTY pass-through: no swap after reset; x_in=5 valid, psum_in=7 -> psum_out=7, x_out=5, x_valid_out=1.
REQ-032 Swap collision: w_act=2, w_shadow=9, w_swap with x_in=1 valid, psum_in=0 -> psum_out=2; next x_in=1 -> 9.
REQ-033 Overflow, ACC_W=16: w=127, x=127, psum_in=32767 -> wraps to 16128-32768-... (wrapped value) with ovf=1 and no macro; 32767 with ovf=1 with PE_SATURATE_EN.
REQ-034 Chain: shift 1,2,3 through two cascaded PEs -> w_out values 2 and 3 after three shifts; mid-chain reset -> all outputs 0, w_ready=0.
REQ-035 Extremes: w=-128, x=-128, psum_in=0 -> psum_out=16384; x_valid_in=0 -> psum_out=psum_in.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the systolic MAC processing element: FSM state type
// and signed saturation limits for an arbitrary accumulator width.
package pe_pkg;

  typedef enum logic [0:0] {
    PE_EMPTY = 1'b0,
    PE_READY = 1'b1
  } pe_state_e;

  // Limits are returned as 64-bit values; callers cast to their ACC_W.
  function automatic longint sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply-add for one PE: psum + w*x with signed overflow detect.
// Clamps to the ACC_W limits when PE_SATURATE_EN is defined, wraps otherwise.
module pe_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [ACC_W-1:0]  psum,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);
  import pe_pkg::*;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W:0]      sum_full;
  logic                       carry_ovf;

  assign prod     = w * x;
  assign prod_ext = ACC_W'(prod);
  // One guard bit: overflow whenever it disagrees with the ACC_W sign bit.
  assign sum_full  = (ACC_W+1)'(psum) + (ACC_W+1)'(prod_ext);
  assign carry_ovf = sum_full[ACC_W] ^ sum_full[ACC_W-1];

`ifdef PE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  always_comb begin
    sum = psum;
    ovf = 1'b0;
    if (en) begin
      ovf = carry_ovf;
      if (carry_ovf) sum = sum_full[ACC_W] ? ACC_MIN : ACC_MAX;
      else           sum = sum_full[ACC_W-1:0];
    end
  end
`else
  always_comb begin
    sum = psum;
    ovf = 1'b0;
    if (en) begin
      ovf = carry_ovf;
      sum = sum_full[ACC_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/systolic_mac_pe.sv
// Weight-stationary systolic MAC processing element with shadow weight chain.
// Optional clamp-on-overflow behaviour selected by macro PE_SATURATE_EN.
//
// state    | meaning
// PE_EMPTY | no active weight yet; psum passes through unchanged
// PE_READY | active weight loaded; valid activations are accumulated
module systolic_mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_valid_in,
  input  logic signed [ACC_W-1:0]  psum_in,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic                     w_shift,
  input  logic                     w_swap,
  output logic signed [DATA_W-1:0] x_out,
  output logic                     x_valid_out,
  output logic signed [ACC_W-1:0]  psum_out,
  output logic signed [DATA_W-1:0] w_out,
  output logic                     w_ready,
  output logic                     ovf
);
  import pe_pkg::*;

  pe_state_e                state;
  logic signed [DATA_W-1:0] w_shadow;
  logic signed [DATA_W-1:0] w_act;
  logic signed [ACC_W-1:0]  mac_sum;
  logic                     mac_ovf;
  logic                     mac_en;

  assign mac_en = x_valid_in && (state == PE_READY);

  pe_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .en   (mac_en),
    .x    (x_in),
    .w    (w_act),
    .psum (psum_in),
    .sum  (mac_sum),
    .ovf  (mac_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= PE_EMPTY;
      x_out       <= '0;
      x_valid_out <= 1'b0;
      psum_out    <= '0;
      w_shadow    <= '0;
      w_act       <= '0;
      ovf         <= 1'b0;
    end else begin
      x_out       <= x_in;
      x_valid_out <= x_valid_in;
      psum_out    <= mac_sum;
      ovf         <= ovf | mac_ovf;
      if (w_shift) w_shadow <= w_in;
      // Swap takes the pre-shift shadow, so shift+swap in one cycle is safe.
      if (w_swap) begin
        w_act <= w_shadow;
        state <= PE_READY;
      end
    end
  end

  assign w_out   = w_shadow;
  assign w_ready = (state == PE_READY);

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: two PEs sharing shift/swap with chained weights,
// checked against an integer arithmetic model (honours PE_SATURATE_EN).
module tb_systolic_mac_pe;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic w_shift = 1'b0, w_swap = 1'b0;

  logic signed [DW-1:0] x0 = '0, x1 = '0, w_in0 = '0;
  logic xv0 = 1'b0, xv1 = 1'b0;
  logic signed [AW-1:0] p0 = '0, p1 = '0;

  logic signed [DW-1:0] x_out0, x_out1, w_out0, w_out1;
  logic xv_out0, xv_out1, rdy0, rdy1, ovf0, ovf1;
  logic signed [AW-1:0] ps_out0, ps_out1;

  int n_checks = 0;
  int n_errors = 0;

  longint m_act[2], m_sh[2], m_rdy[2], m_ovf[2], e_psum[2], e_x[2], e_xv[2];

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW)) u_pe0 (
    .clk(clk), .reset(reset), .x_in(x0), .x_valid_in(xv0), .psum_in(p0),
    .w_in(w_in0), .w_shift(w_shift), .w_swap(w_swap), .x_out(x_out0),
    .x_valid_out(xv_out0), .psum_out(ps_out0), .w_out(w_out0),
    .w_ready(rdy0), .ovf(ovf0));

  systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW)) u_pe1 (
    .clk(clk), .reset(reset), .x_in(x1), .x_valid_in(xv1), .psum_in(p1),
    .w_in(w_out0), .w_shift(w_shift), .w_swap(w_swap), .x_out(x_out1),
    .x_valid_out(xv_out1), .psum_out(ps_out1), .w_out(w_out1),
    .w_ready(rdy1), .ovf(ovf1));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_sh[i] = 0; m_rdy[i] = 0; m_ovf[i] = 0;
      e_psum[i] = 0; e_x[i] = 0; e_xv[i] = 0;
    end
  endtask

  task automatic model_pe(input int i, input longint x, input longint xv,
                          input longint p, input longint win);
    longint s;
    if (xv != 0 && m_rdy[i] != 0) s = p + m_act[i] * x;
    else s = p;
    if (s > MAXV || s < MINV) begin
      m_ovf[i] = 1;
`ifdef PE_SATURATE_EN
      s = (s > MAXV) ? MAXV : MINV;
`else
      s = (s > MAXV) ? s - 65536 : s + 65536;
`endif
    end
    e_psum[i] = s; e_x[i] = x; e_xv[i] = xv;
    if (w_swap) begin
      m_act[i] = m_sh[i];
      m_rdy[i] = 1;
    end
    if (w_shift) m_sh[i] = win;
  endtask

  task automatic check_all();
    check("pe0_psum", ps_out0, e_psum[0]);
    check("pe0_x", x_out0, e_x[0]);
    check("pe0_xv", xv_out0, e_xv[0]);
    check("pe0_wout", w_out0, m_sh[0]);
    check("pe0_ready", rdy0, m_rdy[0]);
    check("pe0_ovf", ovf0, m_ovf[0]);
    check("pe1_psum", ps_out1, e_psum[1]);
    check("pe1_x", x_out1, e_x[1]);
    check("pe1_xv", xv_out1, e_xv[1]);
    check("pe1_wout", w_out1, m_sh[1]);
    check("pe1_ready", rdy1, m_rdy[1]);
    check("pe1_ovf", ovf1, m_ovf[1]);
  endtask

  // Called just after a negedge with inputs already driven; returns at next negedge.
  task automatic run_cycle();
    longint win1;
    win1 = m_sh[0];
    model_pe(0, x0, xv0, p0, w_in0);
    model_pe(1, x1, xv1, p1, win1);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    x0 = '0; x1 = '0; xv0 = 1'b0; xv1 = 1'b0; p0 = '0; p1 = '0;
    w_in0 = '0; w_shift = 1'b0; w_swap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;

    // Pass-through while EMPTY
    x0 = 8'sd5; xv0 = 1'b1; p0 = 16'sd7;
    run_cycle();
    check("empty_psum", ps_out0, 7);
    check("empty_x", x_out0, 5);

    // Load 3, then -4 * 3 + 10
    idle(); w_in0 = 8'sd3; w_shift = 1'b1; run_cycle();
    idle(); w_swap = 1'b1; run_cycle();
    idle(); x0 = -8'sd4; xv0 = 1'b1; p0 = 16'sd10; run_cycle();
    check("load_psum", ps_out0, -2);
    check("load_ready", rdy0, 1);

    // Swap collision: act=2, shadow=9
    do_reset(); idle();
    w_in0 = 8'sd2; w_shift = 1'b1; run_cycle();
    idle(); w_swap = 1'b1; w_in0 = 8'sd9; w_shift = 1'b1; run_cycle();
    idle(); w_swap = 1'b1; x0 = 8'sd1; xv0 = 1'b1; run_cycle();
    check("swap_old_w", ps_out0, 2);
    idle(); x0 = 8'sd1; xv0 = 1'b1; run_cycle();
    check("swap_new_w", ps_out0, 9);

    // Extremes: -128 * -128, then invalid pass-through
    idle(); w_in0 = -8'sd128; w_shift = 1'b1; run_cycle();
    idle(); w_swap = 1'b1; run_cycle();
    idle(); x0 = -8'sd128; xv0 = 1'b1; run_cycle();
    check("ext_psum", ps_out0, 16384);
    idle(); x0 = -8'sd128; p0 = 16'sd1234; run_cycle();
    check("ext_pass", ps_out0, 1234);

    // Overflow 32767 + 127*127
    idle(); w_in0 = 8'sd127; w_shift = 1'b1; run_cycle();
    idle(); w_swap = 1'b1; run_cycle();
    idle(); x0 = 8'sd127; xv0 = 1'b1; p0 = 16'sd32767; run_cycle();
`ifdef PE_SATURATE_EN
    check("ovf_psum", ps_out0, 32767);
`else
    check("ovf_psum", ps_out0, -16640);
`endif
    check("ovf_flag", ovf0, 1);
    idle(); run_cycle();
    check("ovf_sticky", ovf0, 1);

    // Weight chain, then mid-chain reset
    do_reset(); idle();
    for (int k = 1; k <= 3; k++) begin
      w_in0 = DW'(k); w_shift = 1'b1; run_cycle();
    end
    check("chain_w0", w_out0, 3);
    check("chain_w1", w_out1, 2);
    idle(); w_swap = 1'b1; x0 = 8'sd7; xv0 = 1'b1; p0 = 16'sd3; run_cycle();
    do_reset();
    check("midrst_ready", rdy1, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      x0 = DW'($urandom); x1 = DW'($urandom);
      xv0 = ($urandom_range(3) != 0); xv1 = ($urandom_range(3) != 0);
      p0 = AW'($urandom); p1 = AW'($urandom);
      if ($urandom_range(3) == 0) p0 = AW'($urandom_range(2000));
      w_in0 = DW'($urandom);
      w_shift = ($urandom_range(3) == 0);
      w_swap = ($urandom_range(5) == 0);
      run_cycle();
      if (n == 200) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
